// File: rtl/write_burst_req_ctrl.sv
// Write burst request controller: waits for enough FIFO data, issues one AXI
// write burst at a time and reports normal/tail burst completion per frame.
module write_burst_req_ctrl #(
  parameter int unsigned NOR_BURST_LEN = 200,
  parameter int unsigned LSIZE         = 9,
  parameter int unsigned CSIZE         = 12
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             fsync,
  input  logic [CSIZE-1:0] fifo_count,
  input  logic             tail_status,
  input  logic [LSIZE-1:0] tail_len,
  input  logic             tail_leave,
  output logic             burst_req,
  output logic [LSIZE-1:0] burst_len,
  input  logic             burst_ack,
  input  logic             burst_resp,
  output logic             burst_done,
  output logic             tail_done,
  output logic             frame_busy,
  output logic [15:0]      burst_cnt,
  output logic             overrun
);

  localparam int unsigned CW = (CSIZE > LSIZE) ? CSIZE : LSIZE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    WAIT_DATA = 3'd2,
    REQ       = 3'd3,
    WAIT_RESP = 3'd4
  } state_t;

  state_t           state;
  logic             pending;
  logic             is_tail;
  logic [LSIZE-1:0] need_c;
  logic             data_ok_c;

  // Beats required for the next burst and whether the FIFO already holds them
  always_comb begin
    need_c    = tail_status ? tail_len : LSIZE'(NOR_BURST_LEN);
    data_ok_c = CW'(fifo_count) >= CW'(need_c);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      burst_req  <= 1'b0;
      burst_len  <= '0;
      burst_done <= 1'b0;
      tail_done  <= 1'b0;
      frame_busy <= 1'b0;
      burst_cnt  <= '0;
      overrun    <= 1'b0;
      pending    <= 1'b0;
      is_tail    <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      tail_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (fsync) begin
            state      <= SETTLE;
            frame_busy <= 1'b1;
            burst_cnt  <= '0;
          end
        end
        SETTLE: begin
          if (fsync) burst_cnt <= '0;
          else       state     <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (fsync) begin
            burst_cnt <= '0;
            state     <= SETTLE;
          end else if (!tail_leave) begin
            frame_busy <= 1'b0;
            state      <= IDLE;
          end else if (tail_status && (tail_len == '0)) begin
            // Empty tail: nothing to transfer, just acknowledge it upstream
            tail_done <= 1'b1;
            state     <= SETTLE;
          end else if (data_ok_c) begin
            burst_req <= 1'b1;
            burst_len <= need_c;
            is_tail   <= tail_status;
            state     <= REQ;
          end
        end
        REQ: begin
          if (fsync) begin
            overrun <= 1'b1;
            pending <= 1'b1;
          end
          if (burst_ack) begin
            burst_req <= 1'b0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (fsync) begin
            overrun <= 1'b1;
            pending <= 1'b1;
          end
          if (burst_resp) begin
            state <= SETTLE;
            // A frame restart seen during the burst discards its completion
            if (pending || fsync) begin
              burst_cnt <= '0;
              pending   <= 1'b0;
            end else begin
              burst_done <= ~is_tail;
              tail_done  <= is_tail;
              if (burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
